// File: rtl/hdmi_clk_pkg.sv
// ---------------------------------------------------------------------------
// hdmi_clk_pkg
// Shared definitions for the HDMI clock/reset sequencer:
//   - seq_state_t : sequencer state enum
//   - DEF_*       : default cycle counts used as parameter defaults
//   - max_of      : helper used to size the shared cycle counter
// ---------------------------------------------------------------------------
package hdmi_clk_pkg;

  typedef enum logic [2:0] {
    PLL_RESET   = 3'd0,
    WAIT_LOCK   = 3'd1,
    STABLE      = 3'd2,
    RELEASE_SER = 3'd3,
    RUN         = 3'd4
  } seq_state_t;

  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 500000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_SEQ_GAP_CYCLES      = 8;

  localparam logic [3:0] RETRY_MAX = 4'hF;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hdmi_sync2.sv
// ---------------------------------------------------------------------------
// hdmi_sync2
// Two-flop synchronizer for a single asynchronous control bit.
// Ports:
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops
//   d   : asynchronous input bit
//   q   : synchronized output, two destination edges behind d
// ---------------------------------------------------------------------------
module hdmi_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hdmi_clk_reset_seq.sv
// ---------------------------------------------------------------------------
// hdmi_clk_reset_seq
// Brings up the HDMI PLL and releases the serializer and pixel domain resets
// in order once the PLL lock has been stable for long enough. Retries the PLL
// reset after a lock timeout and tears everything down if lock is lost.
// Ports:
//   refclk      : 50 MHz free-running board clock (only clock of this block)
//   rst         : asynchronous active-high reset
//   pll_locked  : raw PLL lock, asynchronous to refclk
//   pll_rst     : PLL reset, high only while in PLL_RESET
//   ser_rst     : 135 MHz TMDS serializer domain reset
//   pix_rst     : 27 MHz pixel domain reset
//   ready       : both domains running on a stable lock
//   lock_lost   : one-cycle pulse when lock drops after ser_rst was released
//   retry_count : number of lock-acquire timeouts, saturating at 15
// ---------------------------------------------------------------------------
module hdmi_clk_reset_seq
  import hdmi_clk_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int SEQ_GAP_CYCLES      = DEF_SEQ_GAP_CYCLES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       ser_rst,
  output logic       pix_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  localparam int MAX_CYCLES = max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                     max_of(LOCK_STABLE_CYCLES, SEQ_GAP_CYCLES));
  localparam int CNT_W = $clog2(MAX_CYCLES) + 1;

  // Terminal counts. STABLE compares against the full count rather than
  // count-1: the transition edge only comes after LOCK_STABLE_CYCLES locked
  // samples have already been counted in STABLE.
  localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(SEQ_GAP_CYCLES - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;

  hdmi_sync2 u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // Sequencer: one shared counter, cleared on every state change so it
  // never has to wrap. All outputs are updated on the same edge as the
  // state they belong to, so they are registered and glitch-free.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= PLL_RESET;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      ser_rst     <= 1'b1;
      pix_rst     <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      lock_lost <= 1'b0;
      case (state)
        PLL_RESET: begin
          if (cnt == PLL_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state   <= PLL_RESET;
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_count != RETRY_MAX) begin
              retry_count <= retry_count + 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE: begin
          // A lock glitch here is not a lost lock: resets were never
          // released, so just restart the acquire window.
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state   <= RELEASE_SER;
            cnt     <= '0;
            ser_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE_SER, RUN: begin
          if (!lock_s) begin
            state     <= PLL_RESET;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            ser_rst   <= 1'b1;
            pix_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b1;
          end else if (state == RELEASE_SER) begin
            if (cnt == GAP_LAST) begin
              state   <= RUN;
              cnt     <= '0;
              pix_rst <= 1'b0;
              ready   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= PLL_RESET;
          cnt     <= '0;
          pll_rst <= 1'b1;
          ser_rst <= 1'b1;
          pix_rst <= 1'b1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_clk_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_hdmi_clk_reset_seq
// Directed bring-up scenarios with randomized timing. Expected outputs are
// computed from the sequencing rules as edge arithmetic: the edge at which
// STABLE is entered fixes ser_rst release (+STB+1) and pix_rst/ready
// (+STB+1+GAP); with no lock, pll_rst and retry_count follow a fixed period.
// ---------------------------------------------------------------------------
module tb_hdmi_clk_reset_seq;

  localparam int PLL = 4;
  localparam int TMO = 100;
  localparam int STB = 16;
  localparam int GAP = 8;
  localparam int PERIOD = PLL + TMO;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       ser_rst;
  logic       pix_rst;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  hdmi_clk_reset_seq #(
    .PLL_RST_CYCLES      (PLL),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .LOCK_STABLE_CYCLES  (STB),
    .SEQ_GAP_CYCLES      (GAP)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .ser_rst     (ser_rst),
    .pix_rst     (pix_rst),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .retry_count (retry_count)
  );

  // 50 MHz reference clock
  always #10 refclk = ~refclk;

  // Safety net so the run always ends even if the sequence stalls
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance n rising edges and settle 1 time unit past each
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
      cyc++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s at edge %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic ePll, input logic eSer, input logic ePix,
                          input logic eRdy, input logic eLost, input int eRetry);
    checkOutput({tag, "_pll_rst"}, 32'(pll_rst), 32'(ePll));
    checkOutput({tag, "_ser_rst"}, 32'(ser_rst), 32'(eSer));
    checkOutput({tag, "_pix_rst"}, 32'(pix_rst), 32'(ePix));
    checkOutput({tag, "_ready"}, 32'(ready), 32'(eRdy));
    checkOutput({tag, "_lock_lost"}, 32'(lock_lost), 32'(eLost));
    checkOutput({tag, "_retry"}, 32'(retry_count), 32'(eRetry));
  endtask

  // Timeouts completed t edges after release when lock never arrives
  function automatic int retriesAt(input int t);
    return (t / PERIOD > 15) ? 15 : t / PERIOD;
  endfunction

  // Check every edge up to lastEdge, given the edge at which STABLE was
  // (or will be) entered for the last time
  task automatic trackRelease(input string tag, input int stableEdge, input int lastEdge,
                              input int pllEnd, input int eRetry);
    int serEdge;
    int pixEdge;
    serEdge = stableEdge + STB + 1;
    pixEdge = serEdge + GAP;
    while (cyc < lastEdge) begin
      applyStimulus(1);
      checkAll(tag, cyc < pllEnd, cyc < serEdge, cyc < pixEdge, !(cyc < pixEdge), 1'b0, eRetry);
    end
  endtask

  initial begin
    int rel;
    int target;
    int stableEdge;
    int t0;
    int t1;
    int s;
    int k;

    // Reset values while rst is held
    rst        = 1'b1;
    pll_locked = 1'b0;
    applyStimulus(3);
    checkAll("reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Scenario 1: no lock ever; PLL reset / timeout period, retries saturate
    rst = 1'b0;
    rel = cyc;
    for (int t = 0; t <= 1700; t++) begin
      if (t > 0) applyStimulus(1);
      checkAll("s1", (t % PERIOD) < PLL, 1'b1, 1'b1, 1'b0, 1'b0, retriesAt(t));
    end

    // Scenario 2: lock arrives at a random point of a WAIT_LOCK window
    target = $urandom_range(PLL, 50);
    while (((cyc - rel) % PERIOD) != target) begin
      applyStimulus(1);
      checkAll("s2_wait", ((cyc - rel) % PERIOD) < PLL, 1'b1, 1'b1, 1'b0, 1'b0, retriesAt(cyc - rel));
    end
    pll_locked = 1'b1;
    // First sampled at edge N = cyc+1, visible to the FSM two edges later
    stableEdge = cyc + 3;
    trackRelease("s2", stableEdge, stableEdge + 30, 0, 15);

    // Scenario 4: lock lost in RUN
    t0 = cyc;
    pll_locked = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(1);
      checkAll("s4", (cyc >= t0 + 3) && (cyc <= t0 + 6), cyc >= t0 + 3, cyc >= t0 + 3,
               cyc < t0 + 3, cyc == t0 + 3, 15);
    end

    // Scenario 3: one-cycle lock glitch 10 cycles into STABLE
    k = $urandom_range(0, 20);
    for (int e = 0; e < k; e++) begin
      applyStimulus(1);
      checkAll("s3_wait", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 15);
    end
    t1 = cyc;
    pll_locked = 1'b1;
    s = t1 + 3;
    // Glitch seen by FSM at s+13, relocked STABLE entry at s+14
    stableEdge = s + 14;
    trackRelease("s3", stableEdge, s + 10, 0, 15);
    pll_locked = 1'b0;
    trackRelease("s3", stableEdge, s + 11, 0, 15);
    pll_locked = 1'b1;
    k = $urandom_range(1, GAP - 2);
    trackRelease("s3", stableEdge, stableEdge + STB + 1 + k, 0, 15);

    // Scenario 5: rst pulsed while in RELEASE_SER takes effect without an edge
    #2;
    rst = 1'b1;
    #1;
    checkAll("s5_async", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(2);
    checkAll("s5_held", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    rst = 1'b0;
    rel = cyc;
    checkAll("s5_t0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    // Lock already present: STABLE entered on the first edge after PLL_RESET
    trackRelease("s5", rel + PLL + 1, rel + PLL + 1 + 30, rel + PLL, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdmi_clk_reset_seq.md
HDMI_CLK_RESET_SEQ -- requirements
Module: hdmi_clk_reset_seq

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: refclk cycles pll_rst is held high per attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 500000: cycles allowed to acquire lock (10 ms at 50 MHz).
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive locked cycles needed before releasing resets.
REQ-004 SHALL have parameter SEQ_GAP_CYCLES, default 8: cycles between ser_rst release and pix_rst release.
REQ-005 SHALL have port refclk, input, 1 bit: 50 MHz free-running board clock; single clock of the block, never a PLL output.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: raw PLL locked, asynchronous to refclk.
REQ-008 SHALL have port pll_rst, output, 1 bit: drives the HDMI PLL rst input.
REQ-009 SHALL have port ser_rst, output, 1 bit: reset for the 135 MHz TMDS serializer domain.
REQ-010 SHALL have port pix_rst, output, 1 bit: reset for the 27 MHz pixel domain.
REQ-011 SHALL have port ready, output, 1 bit: high while both domains are out of reset on a stable lock.
REQ-012 SHALL have port lock_lost, output, 1 bit: one-cycle pulse when lock drops after ser_rst was released.
REQ-013 SHALL have port retry_count, output, 4 bits: count of lock-acquire timeouts, saturating at 15.

Function
REQ-014 SHALL pass pll_locked through a two-flop synchronizer; lock_s refers to its output (2-edge latency).
REQ-015 SHALL implement FSM states PLL_RESET, WAIT_LOCK, STABLE, RELEASE_SER and RUN with one shared cycle counter.
REQ-016 PLL_RESET SHALL hold pll_rst=1 for exactly PLL_RST_CYCLES cycles, then enter WAIT_LOCK with the counter cleared.
REQ-017 WAIT_LOCK SHALL enter STABLE (counter cleared) when lock_s=1.
REQ-018 WAIT_LOCK SHALL, after LOCK_TIMEOUT_CYCLES cycles without lock_s, enter PLL_RESET and increment retry_count (saturating).
REQ-019 STABLE SHALL return to WAIT_LOCK with a fresh timeout when lock_s=0.
REQ-020 STABLE SHALL, after LOCK_STABLE_CYCLES consecutive cycles, enter RELEASE_SER and drive ser_rst=0 on that edge.
REQ-021 RELEASE_SER SHALL, after SEQ_GAP_CYCLES cycles, enter RUN and drive pix_rst=0 and ready=1 on that edge.
REQ-022 RELEASE_SER and RUN SHALL, on lock_s=0, on the same edge: assert ser_rst=pix_rst=1, ready=0 and lock_lost=1 for one cycle, then enter PLL_RESET.
REQ-023 pll_rst SHALL be 1 only in PLL_RESET.
REQ-024 ser_rst SHALL be 0 only in RELEASE_SER and RUN.
REQ-025 pix_rst and ready SHALL change only in RUN.
REQ-026 All outputs SHALL be registered, glitch-free and never combinationally derived from pll_locked.
REQ-027 Counter width SHALL be $clog2 of the largest parameter plus 1; the counter SHALL never wrap mid-state.
REQ-028 retry_count SHALL be cleared only by rst; retry_count at 15 plus another timeout SHALL hold 15.

Reset
REQ-029 rst SHALL asynchronously force state=PLL_RESET, counter=0, synchronizer flops=0, pll_rst=1, ser_rst=1, pix_rst=1, ready=0, lock_lost=0 and retry_count=0.
REQ-030 Assertion of rst mid-sequence SHALL take effect immediately; on deassertion a full PLL_RESET period SHALL restart.

Structure
REQ-031 A shared package (hdmi_clk_pkg) SHALL hold the state enum and the default parameter constants.
REQ-032 The two-flop synchronizer SHALL be a sub-module hdmi_sync2, reusable for other CDC bits.

Verification
REQ-033 Bench parameters SHALL be PLL_RST=4, TIMEOUT=100, STABLE=16, GAP=8.
REQ-034 Scenario 1: rst released, pll_locked held 0 -> pll_rst high 4 cycles; after each 100-cycle timeout retry_count increments, reaching 15 and holding there.
REQ-035 Scenario 2: pll_locked rises, first sampled at edge N -> ser_rst falls at edge N+19, pix_rst and ready rise at N+27.
REQ-036 Scenario 3: pll_locked drops 1 cycle at 10 cycles into STABLE -> FSM returns to WAIT_LOCK, no lock_lost, ser_rst stays 1, full 16-cycle count restarts.
REQ-037 Scenario 4: lock drops in RUN -> lock_lost pulses exactly 1 cycle, ser_rst/pix_rst high and ready low on the same edge, pll_rst high for 4 cycles.
REQ-038 Scenario 5: rst pulsed during RELEASE_SER -> all outputs at reset values immediately, retry_count 0, sequence restarts from PLL_RESET.
